half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 15 +
 rtl/half_adder.sv | 45 ++++
 tb/tb_half_adder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/half_adder_pkg.sv
// Shared half-adder equations and defaults for the adder library.
// Full-adder and ripple blocks import these functions to stay bit-exact with this cell.
package half_adder_pkg;

   localparam int unsigned CNT_W_DEFAULT = 8;

   function automatic logic ha_sum(input logic a, input logic b);
      return a ^ b;
   endfunction

   function automatic logic ha_carry(input logic a, input logic b);
      return a & b;
   endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder with zero-latency sum/carry, a registered copy of both,
// and a saturating counter of clock edges that saw carry=1.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             cnt_clr,
   output logic             sum,
   output logic             carry,
   output logic             sum_q,
   output logic             carry_q,
   output logic [CNT_W-1:0] carry_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Combinational result stays live during reset and with the clock stopped.
   always_comb begin
      sum   = ha_sum(a, b);
      carry = ha_carry(a, b);
   end

   // Clear takes priority over counting; the counter holds at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= 1'b0;
         carry_q   <= 1'b0;
         carry_cnt <= '0;
      end else begin
         sum_q   <= sum;
         carry_q <= carry;
         if (cnt_clr) begin
            carry_cnt <= '0;
         end else if (carry && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_half_adder.sv
// Randomized self-checking bench for half_adder, default and 2-bit counter widths.
module tb_half_adder;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       a       = 1'b0;
   logic       b       = 1'b0;
   logic       cnt_clr = 1'b0;

   logic       sum, carry, sum_q, carry_q;
   logic [7:0] cnt8;
   logic       sum_w2, carry_w2, sum_q_w2, carry_q_w2;
   logic [1:0] cnt2;

   int total = 0;
   int bad   = 0;

   // reference state
   int m_sum_q   = 0;
   int m_carry_q = 0;
   int m_cnt8    = 0;
   int m_cnt2    = 0;

   half_adder dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
      .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q), .carry_cnt(cnt8)
   );

   half_adder #(.CNT_W(2)) dut_w2 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
      .sum(sum_w2), .carry(carry_w2), .sum_q(sum_q_w2), .carry_q(carry_q_w2), .carry_cnt(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_sum();
      return (int'(a) + int'(b)) % 2;
   endfunction

   function automatic int ref_carry();
      return (int'(a) + int'(b)) / 2;
   endfunction

   task automatic check_comb(input string tag);
      check({tag, ".sum"},      32'(sum),      ref_sum());
      check({tag, ".carry"},    32'(carry),    ref_carry());
      check({tag, ".sum_w2"},   32'(sum_w2),   ref_sum());
      check({tag, ".carry_w2"}, 32'(carry_w2), ref_carry());
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".sum_q"},      32'(sum_q),      m_sum_q);
      check({tag, ".carry_q"},    32'(carry_q),    m_carry_q);
      check({tag, ".cnt8"},       32'(cnt8),       m_cnt8);
      check({tag, ".sum_q_w2"},   32'(sum_q_w2),   m_sum_q);
      check({tag, ".carry_q_w2"}, 32'(carry_q_w2), m_carry_q);
      check({tag, ".cnt2"},       32'(cnt2),       m_cnt2);
   endtask

   function automatic int next_cnt(input int cnt, input int width);
      int max_val = (1 << width) - 1;
      if (cnt_clr) return 0;
      if (ref_carry() == 1 && cnt < max_val) return cnt + 1;
      return cnt;
   endfunction

   // One full clock period; inputs must already be settled while clk is low.
   task automatic tick(input string tag);
      #4 clk = 1'b1;
      if (rst_n) begin
         m_sum_q   = ref_sum();
         m_carry_q = ref_carry();
         m_cnt8    = next_cnt(m_cnt8, 8);
         m_cnt2    = next_cnt(m_cnt2, 2);
      end
      #1;
      check_regs(tag);
      check_comb(tag);
      #5 clk = 1'b0;
   endtask

   task automatic drive(input logic va, input logic vb, input logic vclr);
      a = va;
      b = vb;
      cnt_clr = vclr;
   endtask

   // Mid-cycle async reset pulse with the clock held low.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      m_sum_q = 0; m_carry_q = 0; m_cnt8 = 0; m_cnt2 = 0;
      check_regs(tag);
      check_comb(tag);
      #2 rst_n = 1'b1;
   endtask

   int sat_seq[5] = '{1, 2, 3, 3, 3};

   initial begin
      // combinational sweep under reset and with the clock stopped
      for (int i = 0; i < 4; i++) begin
         a = i[1];
         b = i[0];
         #10;
         check_comb("sweep_rst");
         check_regs("sweep_rst");
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = i[1];
         b = i[0];
         #10;
         check_comb("sweep_run");
         check_regs("sweep_run");
      end

      // one-cycle latency
      drive(1'b1, 1'b1, 1'b0);
      tick("lat_n");
      check("lat_n.carry_q_const", 32'(carry_q), 32'd1);
      drive(1'b0, 1'b1, 1'b0);
      tick("lat_n1");
      check("lat_n1.sum_q_const", 32'(sum_q), 32'd1);

      // saturation on the 2-bit counter after a clean start
      drive(1'b0, 1'b0, 1'b1);
      tick("sat_clr");
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         tick("sat");
         check("sat.cnt2_seq", 32'(cnt2), 32'(sat_seq[i]));
      end
      check("sat.cnt8_five", 32'(cnt8), 32'd5);

      // async reset with sum_q=1 and count=5
      drive(1'b1, 1'b0, 1'b0);
      tick("pre_rst");
      check("pre_rst.cnt8_five", 32'(cnt8), 32'd5);
      check("pre_rst.sum_q_one", 32'(sum_q), 32'd1);
      pulse_reset("async_rst");
      check("async_rst.cnt8_zero", 32'(cnt8), 32'd0);

      // clear beats a simultaneous carry
      drive(1'b1, 1'b1, 1'b0);
      tick("clr_up1");
      tick("clr_up2");
      check("clr_up2.cnt8_two", 32'(cnt8), 32'd2);
      drive(1'b1, 1'b1, 1'b1);
      tick("clr_pri");
      check("clr_pri.cnt8_zero", 32'(cnt8), 32'd0);
      drive(1'b1, 1'b1, 1'b0);
      tick("clr_after");
      check("clr_after.cnt8_one", 32'(cnt8), 32'd1);

      // carry-free hold
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         tick("hold");
      end
      check("hold.cnt8_one", 32'(cnt8), 32'd1);

      // random traffic with occasional clears and resets
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 15) == 0));
         tick("rand");
         if ($urandom_range(0, 79) == 0) pulse_reset("rand_rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
